v_logic_pipe: RTL

Parametrised, pipelined bitwise-logic unit for the vector ALU. It is the successor to the fixed 2-bit-opsel AND/OR/XOR pipe and adds the following:
- the full RVV logical/mask-logical op set;
- per-element masking with mask-undisturbed merge;
- element-width (SEW) awareness;
- configurable pipeline depth;
- valid/ready backpressure with a pass-through tag.

It sits between the vector issue/operand-read stage and the result writeback arbiter.

---
 rtl/v_logic_pipe.sv | 99 +++++++++
 1 files changed

// File: rtl/v_logic_pipe.sv
// rtl/v_logic_pipe.sv - pipelined bitwise-logic unit with SEW-aware mask merge and global-stall handshake
module v_logic_pipe #(
  parameter int DATA_WIDTH  = 64,
  parameter int PIPE_STAGES = 6,
  parameter int OPSEL_WIDTH = 3,
  parameter int ID_WIDTH    = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_WIDTH-1:0]   in_vec0,
  input  logic [DATA_WIDTH-1:0]   in_vec1,
  input  logic [DATA_WIDTH-1:0]   in_old,
  input  logic [DATA_WIDTH/8-1:0] in_mask,
  input  logic [1:0]              in_sew,
  input  logic [OPSEL_WIDTH-1:0]  in_opSel,
  input  logic [ID_WIDTH-1:0]     in_id,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [DATA_WIDTH-1:0]   out_vec,
  output logic [ID_WIDTH-1:0]     out_id,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_busy
);

  localparam int NBYTES = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] op_res;
  logic [DATA_WIDTH-1:0] merged;
  logic [NBYTES-1:0]     byte_en;
  logic                  advance;
  logic                  accept;

  logic [DATA_WIDTH-1:0] stg_vec   [PIPE_STAGES];
  logic [ID_WIDTH-1:0]   stg_id    [PIPE_STAGES];
  logic [PIPE_STAGES-1:0] stg_valid;

  assign out_valid = stg_valid[PIPE_STAGES-1];
  assign out_vec   = stg_vec[PIPE_STAGES-1];
  assign out_id    = stg_id[PIPE_STAGES-1];
  assign out_busy  = |stg_valid;
  assign advance   = !out_valid | out_ready;
  assign in_ready  = advance & rst;
  assign accept    = in_valid & in_ready;

  always_comb begin
    op_res = '0;
    unique case (in_opSel)
      3'b000: op_res = in_vec0 & in_vec1;
      3'b001: op_res = in_vec0 | in_vec1;
      3'b010: op_res = in_vec0 ^ in_vec1;
      3'b011: op_res = in_vec0 & ~in_vec1;
      3'b100: op_res = in_vec0 | ~in_vec1;
      3'b101: op_res = ~(in_vec0 & in_vec1);
      3'b110: op_res = ~(in_vec0 | in_vec1);
      3'b111: op_res = ~(in_vec0 ^ in_vec1);
      default: op_res = '0;
    endcase
  end

  // Every element is a whole number of bytes, so the mask is expanded to a
  // byte enable: byte g belongs to element g/(E/8). High mask bits beyond the
  // element count are never selected.
  for (genvar g = 0; g < NBYTES; g++) begin : g_byte
    assign byte_en[g] = (in_sew == 2'b00) ? in_mask[g]     :
                        (in_sew == 2'b01) ? in_mask[g / 2] :
                        (in_sew == 2'b10) ? in_mask[g / 4] :
                                            in_mask[g / 8];
    assign merged[g*8 +: 8] = byte_en[g] ? op_res[g*8 +: 8] : in_old[g*8 +: 8];
  end

  // Stage 1 captures the merged result; empty slots are forced to zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stg_valid[0] <= 1'b0;
      stg_vec[0]   <= '0;
      stg_id[0]    <= '0;
    end else if (advance) begin
      stg_valid[0] <= accept;
      stg_vec[0]   <= accept ? merged : '0;
      stg_id[0]    <= accept ? in_id  : '0;
    end
  end

  for (genvar s = 1; s < PIPE_STAGES; s++) begin : g_stage
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        stg_valid[s] <= 1'b0;
        stg_vec[s]   <= '0;
        stg_id[s]    <= '0;
      end else if (advance) begin
        stg_valid[s] <= stg_valid[s-1];
        stg_vec[s]   <= stg_vec[s-1];
        stg_id[s]    <= stg_id[s-1];
      end
    end
  end

endmodule
